// File: rtl/interrupt_sequencer.sv
`default_nettype none
// ============================================================================
// interrupt_sequencer: two-cycle INTA sequencer with ISR, EOI and rotation.
// Revision 1.0
// ============================================================================
module interrupt_sequencer (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] interrupt,
    input  logic       interrupt_acknowledge,
    input  logic       auto_eoi_config,
    input  logic       rotate_on_auto_eoi,
    input  logic       eoi_cmd,
    input  logic       eoi_specific,
    input  logic       eoi_rotate,
    input  logic [2:0] eoi_level,
    input  logic       set_priority_cmd,
    input  logic [2:0] priority_level,
    input  logic [4:0] vector_base,
    output logic       int_out,
    output logic [7:0] in_service_register,
    output logic [7:0] clear_request,
    output logic [7:0] vector_out,
    output logic       vector_valid,
    output logic [2:0] priority_rotate,
    output logic [7:0] highest_level_in_service
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACK1 = 2'd1;
    localparam logic [1:0] ST_ACK2 = 2'd2;

    logic [1:0] state;
    logic [1:0] state_next;
    logic [2:0] level;
    logic       spurious;

    logic       ack1_take;
    logic       ack2_take;
    logic       auto_eoi;
    logic [2:0] int_level;
    logic [2:0] search_idx;
    logic [2:0] highest_idx;
    logic       isr_found;
    logic [7:0] set_mask;
    logic [7:0] clear_mask;
    logic [7:0] isr_next;
    logic [2:0] rotate_next;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (interrupt != 8'h00)     state_next = ST_ACK1;
            ST_ACK1: if (interrupt_acknowledge)  state_next = ST_ACK2;
            ST_ACK2: if (interrupt_acknowledge)  state_next = ST_IDLE;
            default:                             state_next = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        int_out   = (state == ST_ACK1);
        ack1_take = (state == ST_ACK1) && interrupt_acknowledge;
        ack2_take = (state == ST_ACK2) && interrupt_acknowledge;
    end

    always_comb begin
        int_level = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (interrupt[i]) int_level = 3'(i);
        end
    end

    // Rotated search: start just above the lowest-priority level and wrap.
    always_comb begin
        search_idx  = 3'd0;
        highest_idx = 3'd0;
        isr_found   = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            search_idx = priority_rotate + 3'(i);
            if (!isr_found && in_service_register[search_idx]) begin
                isr_found   = 1'b1;
                highest_idx = search_idx;
            end
        end
        highest_level_in_service = isr_found ? (8'b1 << highest_idx) : 8'h00;
    end

    always_comb begin
        auto_eoi   = ack2_take && auto_eoi_config && !spurious;
        set_mask   = ack1_take ? interrupt : 8'h00;
        clear_mask = 8'h00;
        if (auto_eoi) clear_mask = clear_mask | (8'b1 << level);
        if (eoi_cmd) begin
            if (eoi_specific) clear_mask = clear_mask | (8'b1 << eoi_level);
            else              clear_mask = clear_mask | highest_level_in_service;
        end
        // Set is applied after clear so a same-edge set of the same bit wins.
        isr_next = (in_service_register & ~clear_mask) | set_mask;

        rotate_next = priority_rotate;
        if (auto_eoi && rotate_on_auto_eoi) rotate_next = level;
        if (eoi_cmd && eoi_rotate) begin
            if (eoi_specific)   rotate_next = eoi_level;
            else if (isr_found) rotate_next = highest_idx;
        end
        if (set_priority_cmd) rotate_next = priority_level;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            in_service_register <= 8'h00;
            priority_rotate     <= 3'b111;
            level               <= 3'd0;
            spurious            <= 1'b0;
            clear_request       <= 8'h00;
            vector_out          <= 8'h00;
            vector_valid        <= 1'b0;
        end else begin
            in_service_register <= isr_next;
            priority_rotate     <= rotate_next;
            clear_request       <= set_mask;
            vector_valid        <= ack2_take;
            if (ack1_take) begin
                spurious <= (interrupt == 8'h00);
                level    <= (interrupt == 8'h00) ? 3'd7 : int_level;
            end
            if (ack2_take) begin
                vector_out <= {vector_base, level};
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_interrupt_sequencer.sv
`default_nettype none
// ============================================================================
// tb_interrupt_sequencer: scoreboard bench for interrupt_sequencer.
// Revision 1.0
// ============================================================================
module tb_interrupt_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] interrupt;
    logic       interrupt_acknowledge;
    logic       auto_eoi_config;
    logic       rotate_on_auto_eoi;
    logic       eoi_cmd;
    logic       eoi_specific;
    logic       eoi_rotate;
    logic [2:0] eoi_level;
    logic       set_priority_cmd;
    logic [2:0] priority_level;
    logic [4:0] vector_base;
    logic       int_out;
    logic [7:0] in_service_register;
    logic [7:0] clear_request;
    logic [7:0] vector_out;
    logic       vector_valid;
    logic [2:0] priority_rotate;
    logic [7:0] highest_level_in_service;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_vectors[$];

    interrupt_sequencer dut (
        .clock                    (clock),
        .reset                    (reset),
        .interrupt                (interrupt),
        .interrupt_acknowledge    (interrupt_acknowledge),
        .auto_eoi_config          (auto_eoi_config),
        .rotate_on_auto_eoi       (rotate_on_auto_eoi),
        .eoi_cmd                  (eoi_cmd),
        .eoi_specific             (eoi_specific),
        .eoi_rotate               (eoi_rotate),
        .eoi_level                (eoi_level),
        .set_priority_cmd         (set_priority_cmd),
        .priority_level           (priority_level),
        .vector_base              (vector_base),
        .int_out                  (int_out),
        .in_service_register      (in_service_register),
        .clear_request            (clear_request),
        .vector_out               (vector_out),
        .vector_valid             (vector_valid),
        .priority_rotate          (priority_rotate),
        .highest_level_in_service (highest_level_in_service)
    );

    always #5 clock = ~clock;

    task automatic check_value(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Every vector strobe is matched against the oldest expected vector.
    always @(negedge clock) begin
        if (vector_valid) begin
            if (exp_vectors.size() == 0) begin
                check_value("unexpected_vector_valid", 32'(vector_out), 32'hFFFF_FFFF);
            end else begin
                check_value("vector_out", 32'(vector_out), 32'(exp_vectors.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Full two-acknowledge sequence for a one-hot request.
    task automatic run_irq(input logic [7:0] irq, input logic [2:0] lvl);
        interrupt = irq;
        tick();
        interrupt_acknowledge = 1'b1;
        tick();
        interrupt_acknowledge = 1'b0;
        interrupt = 8'h00;
        tick();
        exp_vectors.push_back({vector_base, lvl});
        interrupt_acknowledge = 1'b1;
        tick();
        interrupt_acknowledge = 1'b0;
    endtask

    task automatic do_eoi(input logic spec, input logic rot, input logic [2:0] lvl);
        eoi_cmd = 1'b1; eoi_specific = spec; eoi_rotate = rot; eoi_level = lvl;
        tick();
        eoi_cmd = 1'b0; eoi_specific = 1'b0; eoi_rotate = 1'b0; eoi_level = 3'd0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; interrupt = 8'h00; interrupt_acknowledge = 1'b0;
        auto_eoi_config = 1'b0; rotate_on_auto_eoi = 1'b0;
        eoi_cmd = 1'b0; eoi_specific = 1'b0; eoi_rotate = 1'b0; eoi_level = 3'd0;
        set_priority_cmd = 1'b0; priority_level = 3'd0; vector_base = 5'h11;
        tick(); tick();
        reset = 1'b0;
        check_value("rst_int_out", 32'(int_out), 32'h0);
        check_value("rst_isr", 32'(in_service_register), 32'h00);
        check_value("rst_clear_request", 32'(clear_request), 32'h00);
        check_value("rst_vector_out", 32'(vector_out), 32'h00);
        check_value("rst_vector_valid", 32'(vector_valid), 32'h0);
        check_value("rst_priority", 32'(priority_rotate), 32'h7);
        check_value("rst_highest", 32'(highest_level_in_service), 32'h00);

        // Basic IR2 sequence with step-by-step checks.
        interrupt = 8'h04;
        tick();
        check_value("ir2_int_out", 32'(int_out), 32'h1);
        interrupt_acknowledge = 1'b1;
        tick();
        interrupt_acknowledge = 1'b0; interrupt = 8'h00;
        check_value("ir2_isr", 32'(in_service_register), 32'h04);
        check_value("ir2_clear_request", 32'(clear_request), 32'h04);
        check_value("ir2_int_out_low", 32'(int_out), 32'h0);
        tick();
        check_value("ir2_clear_pulse_end", 32'(clear_request), 32'h00);
        exp_vectors.push_back(8'h8A);
        interrupt_acknowledge = 1'b1;
        tick();
        interrupt_acknowledge = 1'b0;
        tick();
        check_value("ir2_valid_one_cycle", 32'(vector_valid), 32'h0);
        check_value("ir2_vector_held", 32'(vector_out), 32'h8A);
        check_value("ir2_highest", 32'(highest_level_in_service), 32'h04);
        do_eoi(1'b0, 1'b0, 3'd0);
        check_value("ns_eoi_isr", 32'(in_service_register), 32'h00);

        // Auto-EOI with rotation on IR5.
        auto_eoi_config = 1'b1; rotate_on_auto_eoi = 1'b1;
        run_irq(8'h20, 3'd5);
        check_value("aeoi_isr", 32'(in_service_register), 32'h00);
        check_value("aeoi_priority", 32'(priority_rotate), 32'h5);
        auto_eoi_config = 1'b0; rotate_on_auto_eoi = 1'b0;

        // ISR = 0x81 with IR3 lowest, then rotating non-specific EOI.
        set_priority_cmd = 1'b1; priority_level = 3'd3;
        tick();
        set_priority_cmd = 1'b0;
        run_irq(8'h80, 3'd7);
        run_irq(8'h01, 3'd0);
        check_value("isr81", 32'(in_service_register), 32'h81);
        check_value("isr81_highest", 32'(highest_level_in_service), 32'h80);
        do_eoi(1'b0, 1'b1, 3'd0);
        check_value("ns_rot_isr", 32'(in_service_register), 32'h01);
        check_value("ns_rot_priority", 32'(priority_rotate), 32'h7);
        check_value("ns_rot_highest", 32'(highest_level_in_service), 32'h01);

        // Specific EOI of IR2 on the same edge as ACK1 of IR2: set wins.
        interrupt = 8'h04;
        tick();
        interrupt_acknowledge = 1'b1;
        eoi_cmd = 1'b1; eoi_specific = 1'b1; eoi_level = 3'd2;
        tick();
        interrupt_acknowledge = 1'b0; interrupt = 8'h00;
        eoi_cmd = 1'b0; eoi_specific = 1'b0; eoi_level = 3'd0;
        check_value("set_wins_isr", 32'(in_service_register), 32'h05);
        tick();
        exp_vectors.push_back(8'h8A);
        interrupt_acknowledge = 1'b1;
        tick();
        interrupt_acknowledge = 1'b0;
        do_eoi(1'b1, 1'b1, 3'd0);
        check_value("sp_eoi_isr", 32'(in_service_register), 32'h04);
        check_value("sp_eoi_priority", 32'(priority_rotate), 32'h0);

        // set_priority_cmd beats a rotating EOI; bit 6 already clear.
        set_priority_cmd = 1'b1; priority_level = 3'd1;
        do_eoi(1'b1, 1'b1, 3'd6);
        set_priority_cmd = 1'b0; priority_level = 3'd0;
        check_value("setprio_wins", 32'(priority_rotate), 32'h1);
        check_value("setprio_isr", 32'(in_service_register), 32'h04);
        do_eoi(1'b1, 1'b0, 3'd2);
        check_value("sp_eoi2_isr", 32'(in_service_register), 32'h00);
        do_eoi(1'b0, 1'b1, 3'd0);
        check_value("empty_eoi_priority", 32'(priority_rotate), 32'h1);

        // Spurious: request withdrawn in ACK1.
        interrupt = 8'h08;
        tick();
        interrupt = 8'h00;
        tick();
        check_value("spur_int_hold", 32'(int_out), 32'h1);
        interrupt_acknowledge = 1'b1;
        tick();
        interrupt_acknowledge = 1'b0;
        check_value("spur_isr", 32'(in_service_register), 32'h00);
        check_value("spur_clear_request", 32'(clear_request), 32'h00);
        tick();
        exp_vectors.push_back({5'h11, 3'b111});
        interrupt_acknowledge = 1'b1;
        tick();
        interrupt_acknowledge = 1'b0;

        // Acknowledge in IDLE is ignored.
        interrupt_acknowledge = 1'b1;
        tick();
        interrupt_acknowledge = 1'b0;
        tick();
        check_value("idle_ack_isr", 32'(in_service_register), 32'h00);

        // Reset while in ACK2 aborts the sequence.
        interrupt = 8'h02;
        tick();
        interrupt_acknowledge = 1'b1;
        tick();
        interrupt_acknowledge = 1'b0; interrupt = 8'h00;
        check_value("pre_rst_isr", 32'(in_service_register), 32'h02);
        tick();
        reset = 1'b1; interrupt_acknowledge = 1'b1;
        tick();
        reset = 1'b0;
        check_value("mid_rst_isr", 32'(in_service_register), 32'h00);
        check_value("mid_rst_priority", 32'(priority_rotate), 32'h7);
        check_value("mid_rst_valid", 32'(vector_valid), 32'h0);
        tick();
        interrupt_acknowledge = 1'b0;
        check_value("post_rst_idle", 32'(int_out), 32'h0);
        check_value("post_rst_no_isr", 32'(in_service_register), 32'h00);
        tick(); tick();

        check_value("scoreboard_drained", 32'(exp_vectors.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
